// File: rtl/stopwatch_cu_if.sv
// Stopwatch control-unit bus: raw front-panel buttons in, datapath/FND controls out.
//   i_btn_run/i_btn_clear/i_btn_mode : raw asynchronous buttons, active-high
//   o_run       : time counter count enable
//   o_clear     : time counter synchronous clear, 1-cycle pulse
//   o_disp_sel  : FND page select (0 = msec/sec, 1 = min/hour)
//   o_state     : FSM state, 00 STOP / 01 RUN / 10 CLEAR
// Macro STOPWATCH_LAP_EN adds i_btn_lap and o_lap_hold.
// master = control unit side, slave = panel/datapath side.
interface stopwatch_cu_if;
  logic       i_btn_run;
  logic       i_btn_clear;
  logic       i_btn_mode;
  logic       o_run;
  logic       o_clear;
  logic       o_disp_sel;
  logic [1:0] o_state;
`ifdef STOPWATCH_LAP_EN
  logic       i_btn_lap;
  logic       o_lap_hold;

  modport master (
    input  i_btn_run, i_btn_clear, i_btn_mode, i_btn_lap,
    output o_run, o_clear, o_disp_sel, o_state, o_lap_hold
  );
  modport slave (
    output i_btn_run, i_btn_clear, i_btn_mode, i_btn_lap,
    input  o_run, o_clear, o_disp_sel, o_state, o_lap_hold
  );
`else
  modport master (
    input  i_btn_run, i_btn_clear, i_btn_mode,
    output o_run, o_clear, o_disp_sel, o_state
  );
  modport slave (
    output i_btn_run, i_btn_clear, i_btn_mode,
    input  o_run, o_clear, o_disp_sel, o_state
  );
`endif
endinterface

// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: debounces the front-panel buttons and runs the
// RUN/STOP/CLEAR FSM that drives the time counter enables and FND page select.
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : stopwatch_cu_if.master (buttons in; o_run, o_clear, o_disp_sel,
//          o_state and, with lap enabled, o_lap_hold out)
// Parameter DEBOUNCE_CNT: cycles the synced input must differ from the
// debounced level before it is accepted.
// Macro STOPWATCH_LAP_EN: adds the lap button and the o_lap_hold display freeze.
module stopwatch_cu #(
  parameter int unsigned DEBOUNCE_CNT = 100_000
) (
  input  logic           clk,
  input  logic           rst,
  stopwatch_cu_if.master bus
);

  localparam int unsigned CNT_W     = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam int unsigned BTN_RUN   = 0;
  localparam int unsigned BTN_CLEAR = 1;
  localparam int unsigned BTN_MODE  = 2;
`ifdef STOPWATCH_LAP_EN
  localparam int unsigned BTN_LAP   = 3;
  localparam int unsigned NBTN      = 4;
`else
  localparam int unsigned NBTN      = 3;
`endif

  typedef enum logic [1:0] {
    ST_STOP    = 2'b00,
    ST_RUN     = 2'b01,
    ST_CLEAR   = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_e;

  logic [NBTN-1:0]  btn_raw;
  logic [NBTN-1:0]  sync1_q;
  logic [NBTN-1:0]  sync2_q;
  logic [NBTN-1:0]  db_q;
  logic [NBTN-1:0]  db_d;
  logic [NBTN-1:0]  db_dly_q;
  logic [NBTN-1:0]  btn_pulse;
  logic [CNT_W-1:0] cnt_q [NBTN];
  logic [CNT_W-1:0] cnt_d [NBTN];

  state_e state_q, state_d;
  logic   run_q, run_d;
  logic   clear_q, clear_d;
  logic   disp_sel_q, disp_sel_d;

  // Raw button vector, one bit per debouncer
  assign btn_raw[BTN_RUN]   = bus.i_btn_run;
  assign btn_raw[BTN_CLEAR] = bus.i_btn_clear;
  assign btn_raw[BTN_MODE]  = bus.i_btn_mode;
`ifdef STOPWATCH_LAP_EN
  assign btn_raw[BTN_LAP]   = bus.i_btn_lap;
`endif

  // Debounce counters: accept a new level only after it has persisted long enough
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < int'(NBTN); i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CNT - 1)) begin
        db_d[i]  = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Synchronizers, debounced levels and their one-cycle delay
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      for (int i = 0; i < int'(NBTN); i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      for (int i = 0; i < int'(NBTN); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Rising edge of the debounced level: one pulse per press, none on release
  assign btn_pulse = db_q & ~db_dly_q;

`ifdef STOPWATCH_LAP_EN
  logic lap_hold_q, lap_hold_d;
`endif

  // Next state; outputs are registered from the next state so they track state_q exactly
  always_comb begin
    state_d    = ST_STOP;
    disp_sel_d = disp_sel_q ^ btn_pulse[BTN_MODE];
`ifdef STOPWATCH_LAP_EN
    lap_hold_d = lap_hold_q;
`endif
    case (state_q)
      ST_STOP: begin
        if (btn_pulse[BTN_CLEAR])    state_d = ST_CLEAR;
        else if (btn_pulse[BTN_RUN]) state_d = ST_RUN;
        else                         state_d = ST_STOP;
`ifdef STOPWATCH_LAP_EN
        if (btn_pulse[BTN_LAP]) lap_hold_d = 1'b0;
`endif
      end
      ST_RUN: begin
        state_d = btn_pulse[BTN_RUN] ? ST_STOP : ST_RUN;
`ifdef STOPWATCH_LAP_EN
        if (btn_pulse[BTN_LAP]) lap_hold_d = ~lap_hold_q;
`endif
      end
      // CLEAR lasts one cycle; the illegal code recovers to STOP
      default: state_d = ST_STOP;
    endcase
`ifdef STOPWATCH_LAP_EN
    if (state_d == ST_CLEAR) lap_hold_d = 1'b0;
`endif
    run_d   = (state_d == ST_RUN);
    clear_d = (state_d == ST_CLEAR);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_STOP;
      run_q      <= 1'b0;
      clear_q    <= 1'b0;
      disp_sel_q <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_hold_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      clear_q    <= clear_d;
      disp_sel_q <= disp_sel_d;
`ifdef STOPWATCH_LAP_EN
      lap_hold_q <= lap_hold_d;
`endif
    end
  end

  assign bus.o_run      = run_q;
  assign bus.o_clear    = clear_q;
  assign bus.o_disp_sel = disp_sel_q;
  assign bus.o_state    = state_q;
`ifdef STOPWATCH_LAP_EN
  assign bus.o_lap_hold = lap_hold_q;
`endif

endmodule
